// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer: write-transfer sequencer between the TX FIFO read port
// and the I2C bit engine (i2c_core_clk domain). It sends the address byte,
// pops and presents each data byte, then requests STOP or repeated START and
// reports the completion status.
//
// Ports:
//   i2c_core_clk, rst_n      clock, synchronous active-low reset
//   enable                   rising edge starts a transfer, low aborts it
//   slave_address, byte_count, repeated_start   latched at start
//   fifo_empty, fifo_rdata, fifo_rd_inc         TX FIFO read port
//   ctl_data, ctl_valid, ctl_first, ctl_done, ctl_nack   engine byte handshake
//   ctl_stop, ctl_rstart     one-cycle end-of-transfer requests
//   busy, done, err_code, bytes_sent            status to the register block
module i2c_tx_sequencer #(
  parameter int unsigned DATA_SIZE   = 8,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic                   i2c_core_clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [6:0]             slave_address,
  input  logic [COUNT_WIDTH-1:0] byte_count,
  input  logic                   repeated_start,
  input  logic                   fifo_empty,
  input  logic [DATA_SIZE-1:0]   fifo_rdata,
  output logic                   fifo_rd_inc,
  output logic [DATA_SIZE-1:0]   ctl_data,
  output logic                   ctl_valid,
  output logic                   ctl_first,
  input  logic                   ctl_done,
  input  logic                   ctl_nack,
  output logic                   ctl_stop,
  output logic                   ctl_rstart,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             err_code,
  output logic [COUNT_WIDTH-1:0] bytes_sent
);

  // Stall counter holds 0 .. STALL_LIMIT-1; the last value triggers underflow.
  localparam int unsigned STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_NACK  = 2'd1;
  localparam logic [1:0] ERR_UNDER = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_FETCH = 3'd2,
    S_DATA  = 3'd3,
    S_END   = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   en_q;
  logic [6:0]             addr_q;
  logic                   rs_q;
  logic [COUNT_WIDTH-1:0] remaining;
  logic [DATA_SIZE-1:0]   hold_q;
  logic [STALL_W-1:0]     stall_cnt;

  // Event decode shared by the next-state logic and the datapath.
  logic start;
  logic in_xfer;
  logic handshake;
  logic nack_hit;
  logic ack_hit;
  logic abort;
  logic pop;
  logic stall;
  logic stall_to;
  logic data_ack;

  always_comb begin
    start     = (state == S_IDLE) && enable && !en_q;
    in_xfer   = (state == S_ADDR) || (state == S_FETCH) || (state == S_DATA);
    handshake = ((state == S_ADDR) || (state == S_DATA)) && ctl_done;
    // NACK beats abort; abort beats a plain ACK and any FIFO activity.
    nack_hit  = handshake && ctl_nack;
    abort     = in_xfer && !enable && !nack_hit;
    ack_hit   = handshake && !ctl_nack && enable;
    data_ack  = ack_hit && (state == S_DATA);
    pop       = (state == S_FETCH) && enable && !fifo_empty;
    stall     = (state == S_FETCH) && enable && fifo_empty;
    stall_to  = stall && (stall_cnt == STALL_LAST);
  end

  // State register.
  always_ff @(posedge i2c_core_clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (nack_hit || abort) begin
          state_nxt = S_END;
        end else if (ack_hit) begin
          state_nxt = (remaining != '0) ? S_FETCH : S_END;
        end
      end
      S_FETCH: begin
        if (abort || stall_to) begin
          state_nxt = S_END;
        end else if (pop) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (nack_hit || abort) begin
          state_nxt = S_END;
        end else if (ack_hit) begin
          // remaining is decremented on this edge; 1 means this was the last byte.
          state_nxt = (remaining == COUNT_WIDTH'(1)) ? S_END : S_FETCH;
        end
      end
      S_END:   state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; only the pop strobe depends on the current FIFO/enable inputs.
  always_comb begin
    fifo_rd_inc = 1'b0;
    ctl_data    = '0;
    ctl_valid   = 1'b0;
    ctl_first   = 1'b0;
    ctl_stop    = 1'b0;
    ctl_rstart  = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    case (state)
      S_ADDR: begin
        ctl_valid = 1'b1;
        ctl_first = 1'b1;
        ctl_data  = DATA_SIZE'({addr_q, 1'b0});
      end
      S_FETCH: begin
        // Suppressed while reset is asserted so no byte is lost from the FIFO.
        fifo_rd_inc = pop && rst_n;
      end
      S_DATA: begin
        ctl_valid = 1'b1;
        ctl_data  = hold_q;
      end
      S_END: begin
        if (rs_q && (err_code == ERR_NONE)) begin
          ctl_rstart = 1'b1;
        end else begin
          ctl_stop = 1'b1;
        end
      end
      S_FIN: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: latched request, byte hold register, counters and status.
  always_ff @(posedge i2c_core_clk) begin
    if (!rst_n) begin
      en_q       <= 1'b0;
      addr_q     <= '0;
      rs_q       <= 1'b0;
      remaining  <= '0;
      hold_q     <= '0;
      stall_cnt  <= '0;
      err_code   <= ERR_NONE;
      bytes_sent <= '0;
    end else begin
      en_q <= enable;

      if (start) begin
        addr_q     <= slave_address;
        rs_q       <= repeated_start;
        remaining  <= byte_count;
        err_code   <= ERR_NONE;
        bytes_sent <= '0;
      end

      if (nack_hit) begin
        err_code <= ERR_NACK;
      end else if (abort) begin
        err_code <= ERR_ABORT;
      end else if (stall_to) begin
        err_code <= ERR_UNDER;
      end

      if (pop) begin
        hold_q <= fifo_rdata;
      end

      if (data_ack) begin
        bytes_sent <= bytes_sent + COUNT_WIDTH'(1);
        remaining  <= remaining - COUNT_WIDTH'(1);
      end

      if (stall && !stall_to) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Bench for i2c_tx_sequencer: FIFO and bit-engine models, a table of directed
// transfers, hand-driven timing/abort/reset sequences and randomized transfers
// checked against a transfer-level reference model.
module tb_i2c_tx_sequencer;

  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned STALL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [6:0]    slave_address;
  logic [CW-1:0] byte_count;
  logic          repeated_start;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_inc;
  logic [DW-1:0] ctl_data;
  logic          ctl_valid;
  logic          ctl_first;
  logic          ctl_done;
  logic          ctl_nack;
  logic          ctl_stop;
  logic          ctl_rstart;
  logic          busy;
  logic          done;
  logic [1:0]    err_code;
  logic [CW-1:0] bytes_sent;

  always #5 clk = ~clk;

  i2c_tx_sequencer #(
    .DATA_SIZE  (DW),
    .COUNT_WIDTH(CW),
    .STALL_LIMIT(STALL)
  ) dut (
    .i2c_core_clk  (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .slave_address (slave_address),
    .byte_count    (byte_count),
    .repeated_start(repeated_start),
    .fifo_empty    (fifo_empty),
    .fifo_rdata    (fifo_rdata),
    .fifo_rd_inc   (fifo_rd_inc),
    .ctl_data      (ctl_data),
    .ctl_valid     (ctl_valid),
    .ctl_first     (ctl_first),
    .ctl_done      (ctl_done),
    .ctl_nack      (ctl_nack),
    .ctl_stop      (ctl_stop),
    .ctl_rstart    (ctl_rstart),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code),
    .bytes_sent    (bytes_sent)
  );

  // TX FIFO model: head byte visible combinationally, popped on the strobe.
  logic [7:0] mem [64];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr % 64];
  always @(posedge clk) begin
    if (fifo_rd_inc && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  // Event counters sampled mid-cycle.
  int pop_cnt   = 0;
  int stop_cnt  = 0;
  int rs_cnt    = 0;
  int done_cnt  = 0;
  int stall_cyc = 0;
  always @(negedge clk) begin
    if (fifo_rd_inc) pop_cnt <= pop_cnt + 1;
    if (ctl_stop)    stop_cnt <= stop_cnt + 1;
    if (ctl_rstart)  rs_cnt <= rs_cnt + 1;
    if (done)        done_cnt <= done_cnt + 1;
    if (busy && !ctl_valid && !ctl_stop && !ctl_rstart && !done && fifo_empty)
      stall_cyc <= stall_cyc + 1;
  end

  // Bit-engine model: answers each presented byte after eng_delay cycles.
  logic eng_en    = 1'b0;
  int   eng_delay = 0;
  int   nack_idx  = -1;
  logic eng_done  = 1'b0;
  logic eng_nack  = 1'b0;
  logic man_done  = 1'b0;
  logic man_nack  = 1'b0;
  logic [7:0] cap_data[$];
  logic       cap_first[$];
  assign ctl_done = eng_done | man_done;
  assign ctl_nack = eng_nack | man_nack;

  initial begin
    int wait_cnt;
    int byte_idx;
    wait_cnt = 0;
    byte_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      eng_nack = 1'b0;
      if (eng_en && ctl_valid) begin
        if (wait_cnt < eng_delay) begin
          wait_cnt++;
        end else begin
          if (ctl_first) begin
            cap_data.delete();
            cap_first.delete();
            byte_idx = 0;
          end
          cap_data.push_back(ctl_data);
          cap_first.push_back(ctl_first);
          eng_done = 1'b1;
          eng_nack = (byte_idx == nack_idx);
          byte_idx++;
          wait_cnt = 0;
        end
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_data [17];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_fifo(input int n);
    wr_ptr = rd_ptr;
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr % 64] = exp_data[i];
      wr_ptr = wr_ptr + 1;
    end
  endtask

  // Transfer-level reference: walk the bytes, stopping at NACK or starvation.
  task automatic model(input int count, input int avail, input int nack, input logic rs,
                       output logic [1:0] err, output int sent, output int pops,
                       output logic stop, output logic rstart, output int stalls);
    err  = 2'd0;
    sent = 0;
    pops = 0;
    if (nack == 0) begin
      err = 2'd1;
    end else begin
      for (int i = 1; i <= count; i++) begin
        if (i > avail) begin
          err = 2'd2;
          break;
        end
        pops = i;
        if (nack == i) begin
          err = 2'd1;
          break;
        end
        sent = i;
      end
    end
    stop   = !(rs && (err == 2'd0));
    rstart = !stop;
    stalls = (err == 2'd2) ? int'(STALL) : 0;
  endtask

  task automatic run_xfer(input string tag, input logic [6:0] addr, input int count,
                          input logic rs, input int avail, input int nack, input int delay,
                          input logic [1:0] e_err, input int e_sent, input int e_pops,
                          input logic e_stop, input logic e_rstart, input int e_stalls);
    int p0, s0, r0, d0, st0;
    int got;
    int seq_ok;
    fill_fifo(avail);
    slave_address  = addr;
    byte_count     = CW'(count);
    repeated_start = rs;
    eng_en    = 1'b1;
    eng_delay = delay;
    nack_idx  = nack;
    p0 = pop_cnt; s0 = stop_cnt; r0 = rs_cnt; d0 = done_cnt; st0 = stall_cyc;
    enable = 1'b1;
    got = 0;
    for (int k = 0; k < 600 && got == 0; k++) begin
      cyc();
      if (k == 0) begin
        // Request inputs are latched at start; disturb them afterwards.
        slave_address  = addr ^ 7'h7F;
        byte_count     = ~CW'(count);
        repeated_start = ~rs;
      end
      if (done_cnt != d0) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1);
    // enable held high after completion must not start another transfer
    repeat (5) cyc();
    chk({tag, "_no_retrigger_busy"}, int'(busy), 0);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_err"}, int'(err_code), int'(e_err));
    chk({tag, "_bytes_sent"}, int'(bytes_sent), e_sent);
    chk({tag, "_pops"}, pop_cnt - p0, e_pops);
    chk({tag, "_stops"}, stop_cnt - s0, int'(e_stop));
    chk({tag, "_rstarts"}, rs_cnt - r0, int'(e_rstart));
    chk({tag, "_stall_cycles"}, stall_cyc - st0, e_stalls);
    chk({tag, "_fifo_left"}, wr_ptr - rd_ptr, avail - e_pops);
    chk({tag, "_seq_len"}, cap_data.size(), 1 + e_pops);
    seq_ok = 0;
    if (cap_data.size() == 1 + e_pops) begin
      seq_ok = (cap_data[0] == {addr, 1'b0}) && cap_first[0];
      for (int j = 1; j < cap_data.size(); j++) begin
        if (cap_data[j] != exp_data[j-1] || cap_first[j]) seq_ok = 0;
      end
    end
    chk({tag, "_seq_data"}, seq_ok, 1);
    enable = 1'b0;
    eng_en = 1'b0;
    cyc();
    cyc();
  endtask

  typedef struct {
    logic [6:0] addr;
    int         count;
    logic       rs;
    int         avail;
    int         nack;
    logic [7:0] base;
    logic [7:0] step;
    logic [1:0] e_err;
    int         e_sent;
    int         e_pops;
    logic       e_stop;
    logic       e_rstart;
    int         e_stalls;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int p0, s0;
    logic [1:0] m_err;
    int m_sent, m_pops, m_stalls, r_count, r_avail, r_nack, r_delay;
    logic m_stop, m_rstart, r_rs;
    logic [6:0] r_addr;

    //          addr   cnt rs    avl nack base   step   err    snt pop stop  rstrt stall
    vecs[0] = '{7'h50, 3,  1'b0, 3,  -1, 8'hA1, 8'h11, 2'd0, 3,  3,  1'b1, 1'b0, 0};
    vecs[1] = '{7'h22, 2,  1'b0, 3,  2,  8'h10, 8'h01, 2'd1, 1,  2,  1'b1, 1'b0, 0};
    vecs[2] = '{7'h3C, 2,  1'b0, 1,  -1, 8'h5A, 8'h01, 2'd2, 1,  1,  1'b1, 1'b0, 4};
    vecs[3] = '{7'h11, 1,  1'b1, 1,  -1, 8'hC4, 8'h00, 2'd0, 1,  1,  1'b0, 1'b1, 0};
    vecs[4] = '{7'h11, 1,  1'b1, 1,  0,  8'hC4, 8'h00, 2'd1, 0,  0,  1'b1, 1'b0, 0};
    vecs[5] = '{7'h7F, 0,  1'b0, 0,  -1, 8'h00, 8'h00, 2'd0, 0,  0,  1'b1, 1'b0, 0};
    vecs[6] = '{7'h01, 15, 1'b1, 16, -1, 8'h03, 8'h07, 2'd0, 15, 15, 1'b0, 1'b1, 0};
    vecs[7] = '{7'h2A, 1,  1'b1, 0,  -1, 8'h00, 8'h00, 2'd2, 0,  0,  1'b1, 1'b0, 4};

    rst_n = 1'b0;
    enable = 1'b0;
    slave_address = 7'h00;
    byte_count = '0;
    repeated_start = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(ctl_valid), 0);
    chk("rst_pop", int'(fifo_rd_inc), 0);
    chk("rst_err", int'(err_code), 0);
    chk("rst_sent", int'(bytes_sent), 0);
    chk("rst_stop", int'(ctl_stop), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // A: start latency, data latency, abort with a same-cycle ctl_done.
    slave_address = 7'h50;
    byte_count = 4'd2;
    repeated_start = 1'b0;
    exp_data[0] = 8'h11;
    exp_data[1] = 8'h22;
    fill_fifo(2);
    p0 = pop_cnt;
    enable = 1'b1;
    @(negedge clk);
    chk("A_pre_busy", int'(busy), 0);
    cyc();
    man_done = 1'b1;
    @(negedge clk);
    chk("A_addr_valid", int'(ctl_valid), 1);
    chk("A_addr_first", int'(ctl_first), 1);
    chk("A_addr_data", int'(ctl_data), 'hA0);
    chk("A_addr_busy", int'(busy), 1);
    cyc();
    man_done = 1'b0;
    @(negedge clk);
    chk("A_fetch_valid", int'(ctl_valid), 0);
    chk("A_fetch_pop", int'(fifo_rd_inc), 1);
    cyc();
    @(negedge clk);
    chk("A_data_valid", int'(ctl_valid), 1);
    chk("A_data_first", int'(ctl_first), 0);
    chk("A_data_byte", int'(ctl_data), 'h11);
    cyc();
    enable = 1'b0;
    man_done = 1'b1;
    @(negedge clk);
    chk("A_data_held", int'(ctl_data), 'h11);
    cyc();
    man_done = 1'b0;
    @(negedge clk);
    chk("A_end_stop", int'(ctl_stop), 1);
    chk("A_end_rstart", int'(ctl_rstart), 0);
    chk("A_end_err", int'(err_code), 3);
    chk("A_end_valid", int'(ctl_valid), 0);
    chk("A_end_sent", int'(bytes_sent), 0);
    cyc();
    @(negedge clk);
    chk("A_fin_done", int'(done), 1);
    cyc();
    @(negedge clk);
    chk("A_idle_busy", int'(busy), 0);
    chk("A_idle_err", int'(err_code), 3);
    chk("A_pops", pop_cnt - p0, 1);
    wr_ptr = rd_ptr;

    // B: NACK on the address byte with enable dropping the same cycle.
    p0 = pop_cnt;
    cyc();
    enable = 1'b1;
    cyc();
    enable = 1'b0;
    man_done = 1'b1;
    man_nack = 1'b1;
    @(negedge clk);
    chk("B_addr_valid", int'(ctl_valid), 1);
    cyc();
    man_done = 1'b0;
    man_nack = 1'b0;
    @(negedge clk);
    chk("B_end_stop", int'(ctl_stop), 1);
    chk("B_end_err", int'(err_code), 1);
    cyc();
    cyc();
    @(negedge clk);
    chk("B_idle_busy", int'(busy), 0);
    chk("B_pops", pop_cnt - p0, 0);

    // D: reset while waiting in FETCH just as a byte arrives.
    cyc();
    enable = 1'b1;
    cyc();
    man_done = 1'b1;
    cyc();
    man_done = 1'b0;
    @(negedge clk);
    chk("D_fetch_busy", int'(busy), 1);
    chk("D_fetch_valid", int'(ctl_valid), 0);
    chk("D_fetch_nopop", int'(fifo_rd_inc), 0);
    p0 = pop_cnt;
    s0 = stop_cnt;
    cyc();
    mem[wr_ptr % 64] = 8'h77;
    wr_ptr = wr_ptr + 1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("D_rst_pop_gated", int'(fifo_rd_inc), 0);
    cyc();
    @(negedge clk);
    chk("D_rst_busy", int'(busy), 0);
    chk("D_rst_valid", int'(ctl_valid), 0);
    chk("D_rst_first", int'(ctl_first), 0);
    chk("D_rst_data", int'(ctl_data), 0);
    chk("D_rst_pop", int'(fifo_rd_inc), 0);
    chk("D_rst_stop", int'(ctl_stop), 0);
    chk("D_rst_done", int'(done), 0);
    chk("D_rst_err", int'(err_code), 0);
    chk("D_rst_sent", int'(bytes_sent), 0);
    chk("D_rst_no_pop", pop_cnt - p0, 0);
    chk("D_rst_no_stop", stop_cnt - s0, 0);
    cyc();
    enable = 1'b0;
    cyc();
    rst_n = 1'b1;
    wr_ptr = rd_ptr;
    cyc();

    // Directed transfer table.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 17; i++) exp_data[i] = 8'(vecs[v].base + vecs[v].step * 8'(i));
      run_xfer($sformatf("T%0d", v), vecs[v].addr, vecs[v].count, vecs[v].rs,
               vecs[v].avail, vecs[v].nack, v % 3, vecs[v].e_err, vecs[v].e_sent,
               vecs[v].e_pops, vecs[v].e_stop, vecs[v].e_rstart, vecs[v].e_stalls);
    end

    // Randomized transfers against the reference model.
    for (int r = 0; r < 40; r++) begin
      r_count = int'($urandom_range(0, 15));
      r_avail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_count))
                                            : r_count + int'($urandom_range(0, 1));
      r_nack  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, r_count)) : -1;
      r_rs    = 1'($urandom_range(0, 1));
      r_addr  = 7'($urandom);
      r_delay = int'($urandom_range(0, 2));
      for (int i = 0; i < 17; i++) exp_data[i] = 8'($urandom);
      model(r_count, r_avail, r_nack, r_rs, m_err, m_sent, m_pops, m_stop, m_rstart, m_stalls);
      run_xfer($sformatf("R%0d", r), r_addr, r_count, r_rs, r_avail, r_nack, r_delay,
               m_err, m_sent, m_pops, m_stop, m_rstart, m_stalls);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
